// File: rtl/SB_codex_pkg.sv
// Shared sideband message codes, SBINIT state encoding and sizing helpers.
package SB_codex_pkg;

  typedef enum logic [1:0] {
    SBINIT_OUT_OF_RESET = 2'd0,
    SBINIT_DONE_REQ     = 2'd1,
    SBINIT_DONE_RESP    = 2'd2,
    SBINIT_MSG_RSVD     = 2'd3
  } SB_msg_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PATTERN   = 3'd1,
    OOR       = 3'd2,
    DONE_XCHG = 3'd3,
    DONE      = 3'd4,
    FAIL      = 3'd5
  } sbinit_state_t;

  localparam int unsigned PATTERN_GAP_CYCLES = 128;

  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sb_pattern_lane_cnt.sv
// Per-lane saturating count of clock-pattern detections; the count is dropped
// when the next detection does not follow within PATTERN_GAP_CYCLES.
module sb_pattern_lane_cnt
  import SB_codex_pkg::*;
#(
  parameter int unsigned PATTERN_ITER = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic det_i,
  output logic reached_o
);

  localparam int unsigned CW = $clog2(PATTERN_ITER + 1);
  localparam int unsigned GW = $clog2(PATTERN_GAP_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    cnt_d = cnt_q;
    gap_d = gap_q;
    if (!active_i) begin
      cnt_d = '0;
      gap_d = '0;
    end else if (det_i) begin
      gap_d = '0;
      if (cnt_q != CW'(PATTERN_ITER)) cnt_d = cnt_q + CW'(1);
      else                            cnt_d = cnt_q;
    end else if (cnt_q != '0) begin
      // last gap slot used up without a new detection: start over
      if (gap_q == GW'(PATTERN_GAP_CYCLES - 1)) begin
        cnt_d = '0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end

  assign reached_o = (cnt_q == CW'(PATTERN_ITER));

endmodule

// File: rtl/sbinit_multilane.sv
// SBINIT sequencer over NUM_LANES redundant sideband lanes.
// Optional internal state timeout: define SBINIT_TIMEOUT_EN.
module sbinit_multilane
  import SB_codex_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 2,
  parameter int unsigned PATTERN_ITER   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  localparam int unsigned LSW           = lane_idx_w(NUM_LANES)
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 enable_i,
  output logic [NUM_LANES-1:0] pattern_tx_en_o,
  input  logic [NUM_LANES-1:0] pattern_det_i,
  output logic [LSW-1:0]       lane_sel_o,
  output SB_msg_t              SB_TX_msg_o,
  output logic                 SB_TX_msg_valid_o,
  input  logic                 SB_TX_msg_sendNextFlag_i,
  input  SB_msg_t              SB_RX_msg_i,
  input  logic                 SB_RX_msg_valid_i,
  output logic                 SB_RX_msg_req_o,
  output logic                 enable_SB_tx,
  output logic                 enable_SB_rx,
  output logic                 reset_state_timeout_counter_o,
  output logic                 SBINIT_done_o,
  output logic                 SBINIT_fail_o
);

  sbinit_state_t  state_q, state_d;
  logic [LSW-1:0] lane_sel_q, lane_sel_d, first_sel_s;
  SB_msg_t        tx_msg_q, tx_msg_d;
  logic           tx_valid_q, tx_valid_d;
  logic           oor_rcvd_q, oor_rcvd_d;
  logic           req_sent_q, req_sent_d, req_rcvd_q, req_rcvd_d;
  logic           resp_sent_q, resp_sent_d, resp_rcvd_q, resp_rcvd_d;
  logic           pulse_q, done_q;
  logic           accept_s, rx_req_s, rx_fire_s, timeout_s;
  logic [NUM_LANES-1:0] reached_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sb_pattern_lane_cnt #(.PATTERN_ITER(PATTERN_ITER)) u_cnt (
      .clk_i     (clk_100MHz),
      .reset_i   (reset),
      .active_i  (state_q == PATTERN),
      .det_i     (pattern_det_i[g]),
      .reached_o (reached_s[g])
    );
  end

`ifdef SBINIT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          fail_q;

  always_ff @(posedge clk_100MHz) begin
    if (reset)                                 to_cnt_q <= '0;
    else if (state_d != state_q)               to_cnt_q <= '0;
    else if (to_cnt_q != TW'(TIMEOUT_CYCLES))  to_cnt_q <= to_cnt_q + TW'(1);
    else                                       to_cnt_q <= to_cnt_q;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) fail_q <= 1'b0;
    else       fail_q <= (state_d == FAIL);
  end

  assign timeout_s = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) &&
                     (state_q inside {PATTERN, OOR, DONE_XCHG});
  assign SBINIT_fail_o = fail_q;
`else
  assign timeout_s     = 1'b0;
  assign SBINIT_fail_o = 1'b0;
`endif

  assign accept_s  = tx_valid_q && SB_TX_msg_sendNextFlag_i;
  assign rx_req_s  = (state_q == OOR) || (state_q == DONE_XCHG);
  assign rx_fire_s = SB_RX_msg_valid_i && rx_req_s;

  always_comb begin
    first_sel_s = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (reached_s[i]) first_sel_s = LSW'(i);
      else              first_sel_s = first_sel_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_sel_d  = lane_sel_q;
    tx_msg_d    = tx_msg_q;
    tx_valid_d  = tx_valid_q;
    oor_rcvd_d  = oor_rcvd_q;
    req_sent_d  = req_sent_q;
    req_rcvd_d  = req_rcvd_q;
    resp_sent_d = resp_sent_q;
    resp_rcvd_d = resp_rcvd_q;
    if (!enable_i) begin
      state_d     = IDLE;
      lane_sel_d  = '0;
      tx_msg_d    = SBINIT_OUT_OF_RESET;
      tx_valid_d  = 1'b0;
      oor_rcvd_d  = 1'b0;
      req_sent_d  = 1'b0;
      req_rcvd_d  = 1'b0;
      resp_sent_d = 1'b0;
      resp_rcvd_d = 1'b0;
    end else if (timeout_s) begin
      state_d    = FAIL;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = PATTERN;
        PATTERN: begin
          if (|reached_s) begin
            lane_sel_d = first_sel_s;
            state_d    = OOR;
          end else begin
            state_d = PATTERN;
          end
        end
        OOR: begin
          // a fast partner may already be asking for DONE; keep it for later
          if (rx_fire_s && SB_RX_msg_i == SBINIT_OUT_OF_RESET) oor_rcvd_d = 1'b1;
          else if (rx_fire_s && SB_RX_msg_i == SBINIT_DONE_REQ) req_rcvd_d = 1'b1;
          else oor_rcvd_d = oor_rcvd_q;
          if (accept_s) begin
            tx_valid_d = 1'b0;
          end else begin
            tx_msg_d   = SBINIT_OUT_OF_RESET;
            tx_valid_d = 1'b1;
          end
          if (oor_rcvd_d && accept_s) state_d = DONE_XCHG;
          else                        state_d = OOR;
        end
        DONE_XCHG: begin
          if (rx_fire_s && SB_RX_msg_i == SBINIT_DONE_REQ) req_rcvd_d = 1'b1;
          else if (rx_fire_s && SB_RX_msg_i == SBINIT_DONE_RESP) resp_rcvd_d = 1'b1;
          else req_rcvd_d = req_rcvd_q;
          if (accept_s) begin
            if (tx_msg_q == SBINIT_DONE_RESP)     resp_sent_d = 1'b1;
            else if (tx_msg_q == SBINIT_DONE_REQ) req_sent_d  = 1'b1;
            else                                  req_sent_d  = req_sent_q;
            tx_valid_d = 1'b0;
          end else if (!tx_valid_q) begin
            if (req_rcvd_d && !resp_sent_q) begin
              tx_msg_d   = SBINIT_DONE_RESP;
              tx_valid_d = 1'b1;
            end else if (!req_sent_q) begin
              tx_msg_d   = SBINIT_DONE_REQ;
              tx_valid_d = 1'b1;
            end else begin
              tx_valid_d = 1'b0;
            end
          end else begin
            tx_valid_d = tx_valid_q;
          end
          if (req_sent_q && req_rcvd_q && resp_sent_q && resp_rcvd_q) state_d = DONE;
          else                                                         state_d = DONE_XCHG;
        end
        DONE: begin
          tx_valid_d = 1'b0;
          state_d    = DONE;
        end
        FAIL: begin
          tx_valid_d = 1'b0;
          state_d    = FAIL;
        end
        default: begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_sel_q  <= '0;
      tx_msg_q    <= SBINIT_OUT_OF_RESET;
      tx_valid_q  <= 1'b0;
      oor_rcvd_q  <= 1'b0;
      req_sent_q  <= 1'b0;
      req_rcvd_q  <= 1'b0;
      resp_sent_q <= 1'b0;
      resp_rcvd_q <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_sel_q  <= lane_sel_d;
      tx_msg_q    <= tx_msg_d;
      tx_valid_q  <= tx_valid_d;
      oor_rcvd_q  <= oor_rcvd_d;
      req_sent_q  <= req_sent_d;
      req_rcvd_q  <= req_rcvd_d;
      resp_sent_q <= resp_sent_d;
      resp_rcvd_q <= resp_rcvd_d;
      pulse_q     <= (state_d != state_q);
      done_q      <= (state_d == DONE);
    end
  end

  assign pattern_tx_en_o               = {NUM_LANES{state_q == PATTERN}};
  assign enable_SB_tx                  = state_q inside {PATTERN, OOR, DONE_XCHG};
  assign enable_SB_rx                  = state_q inside {PATTERN, OOR, DONE_XCHG};
  assign SB_RX_msg_req_o               = rx_req_s;
  assign lane_sel_o                    = lane_sel_q;
  assign SB_TX_msg_o                   = tx_msg_q;
  assign SB_TX_msg_valid_o             = tx_valid_q;
  assign reset_state_timeout_counter_o = pulse_q;
  assign SBINIT_done_o                 = done_q;

endmodule
